// File: rtl/imuldiv_three_input_req_collector.sv
// Collects three 32-bit operand words (A, B, C) plus fn into one mul/div request.
// Optional IMULDIV_COLLECT_OVERLAP_EN lets word A of the next op enter while the
// current request is handed off.
module imuldiv_three_input_req_collector #(
  parameter int W    = 32,
  parameter int FN_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [FN_W-1:0] in_fn,
  input  logic [W-1:0]    in_data,
  input  logic            in_val,
  output logic            in_rdy,
  output logic [FN_W-1:0] muldivreq_msg_fn,
  output logic [W-1:0]    muldivreq_msg_a,
  output logic [W-1:0]    muldivreq_msg_b,
  output logic [W-1:0]    muldivreq_msg_c,
  output logic            muldivreq_val,
  input  logic            muldivreq_rdy,
  output logic            err_fn_mismatch
);

  typedef enum logic [1:0] {S_A, S_B, S_C, S_OUT} state_t;

  state_t state, state_nxt;
  logic   word_xfer, req_xfer;

  assign muldivreq_val = (state == S_OUT);
`ifdef IMULDIV_COLLECT_OVERLAP_EN
  assign in_rdy = (state != S_OUT) | muldivreq_rdy;
`else
  assign in_rdy = (state != S_OUT);
`endif
  assign word_xfer = in_val & in_rdy;
  assign req_xfer  = muldivreq_val & muldivreq_rdy;

  always_ff @(posedge clk) begin
    if (reset) state <= S_A;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_A:   if (word_xfer) state_nxt = S_B;
      S_B:   if (word_xfer) state_nxt = S_C;
      S_C:   if (word_xfer) state_nxt = S_OUT;
      S_OUT: begin
        // A word accepted alongside the hand-off is the next op's word A.
        if (req_xfer) state_nxt = word_xfer ? S_B : S_A;
      end
      default: state_nxt = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      muldivreq_msg_fn <= '0;
      muldivreq_msg_a  <= '0;
      muldivreq_msg_b  <= '0;
      muldivreq_msg_c  <= '0;
      err_fn_mismatch  <= 1'b0;
    end else if (word_xfer) begin
      case (state)
        S_A, S_OUT: begin
          muldivreq_msg_fn <= in_fn;
          muldivreq_msg_a  <= in_data;
        end
        S_B:     muldivreq_msg_b <= in_data;
        S_C:     muldivreq_msg_c <= in_data;
        default: ;
      endcase
      // fn is owned by word A; later words only flag disagreement.
      if ((state == S_B || state == S_C) && in_fn != muldivreq_msg_fn)
        err_fn_mismatch <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imuldiv_three_input_req_collector.sv
// Bench for imuldiv_three_input_req_collector: vector table, corner sequences and
// random traffic against a queue-based reference model.
module tb_imuldiv_three_input_req_collector;
  localparam int W = 32, FN_W = 3;
`ifdef IMULDIV_COLLECT_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic [FN_W-1:0] in_fn = '0;
  logic [W-1:0] in_data = '0;
  logic in_val = 1'b0, in_rdy, muldivreq_val, muldivreq_rdy = 1'b0, err_fn_mismatch;
  logic [FN_W-1:0] muldivreq_msg_fn;
  logic [W-1:0] muldivreq_msg_a, muldivreq_msg_b, muldivreq_msg_c;

  imuldiv_three_input_req_collector #(.W(W), .FN_W(FN_W)) dut (
    .clk(clk), .reset(reset), .in_fn(in_fn), .in_data(in_data), .in_val(in_val),
    .in_rdy(in_rdy), .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_msg_c(muldivreq_msg_c),
    .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
    .err_fn_mismatch(err_fn_mismatch));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, dut_req = 0;

  // Reference model: words gathered so far, plus at most one pending request.
  logic [W-1:0]    got[$];
  logic [FN_W-1:0] cur_fn, r_fn;
  logic [W-1:0]    r_a, r_b, r_c;
  bit m_pend, m_err;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_val = 1'b0; muldivreq_rdy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    got.delete(); m_pend = 0; m_err = 0;
    chk("rst_val", muldivreq_val, 0);
    chk("rst_rdy", in_rdy, 1);
    chk("rst_err", err_fn_mismatch, 0);
    chk("rst_regs", {muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_msg_c}, 0);
  endtask

  // One cycle: drive, check against the model, clock, advance the model.
  task automatic cyc(input bit v, input logic [FN_W-1:0] f, input logic [W-1:0] d,
                     input bit mr, output bit acc);
    bit prdy, rx;
    in_val = v; in_fn = f; in_data = d; muldivreq_rdy = mr;
    #1;
    prdy = !m_pend || (OVL && mr);
    chk("in_rdy", in_rdy, prdy);
    chk("val", muldivreq_val, m_pend);
    chk("err", err_fn_mismatch, m_err);
    if (m_pend) begin
      chk("fn", muldivreq_msg_fn, r_fn);
      chk("abc", {muldivreq_msg_a, muldivreq_msg_b, muldivreq_msg_c}, {r_a, r_b, r_c});
    end
    if (muldivreq_val && mr) dut_req++;
    @(posedge clk);
    acc = v && prdy;
    rx = m_pend && mr;
    if (rx) m_pend = 0;
    if (acc) begin
      if (got.size() == 0) cur_fn = f;
      else if (f != cur_fn) m_err = 1;
      got.push_back(d);
      if (got.size() == 3) begin
        m_pend = 1; r_fn = cur_fn;
        r_a = got[0]; r_b = got[1]; r_c = got[2];
        got.delete();
      end
    end
    #1;
  endtask

  typedef struct {
    bit rst; bit v; logic [FN_W-1:0] f; logic [W-1:0] d; bit mr;
    bit e_rdy; bit e_val; logic [FN_W-1:0] e_fn; logic [W-1:0] e_a, e_b, e_c;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit rst, bit v, logic [FN_W-1:0] f, logic [W-1:0] d, bit mr,
                              bit e_rdy, bit e_val, logic [FN_W-1:0] e_fn,
                              logic [W-1:0] e_a, logic [W-1:0] e_b, logic [W-1:0] e_c);
    vec_t t;
    t.rst = rst; t.v = v; t.f = f; t.d = d; t.mr = mr; t.e_rdy = e_rdy; t.e_val = e_val;
    t.e_fn = e_fn; t.e_a = e_a; t.e_b = e_b; t.e_c = e_c;
    tbl.push_back(t);
  endfunction

  initial begin
    bit acc;
    int wi, base;
    int vc[$];
    logic [W-1:0] w6[6];

    // Basic request (expectations sampled just after the edge).
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 5, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 7, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 9, 1, OVL, 1, 1, 5, 7, 9);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    // Backpressure: request held for five cycles with words offered.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 3, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3, 2, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 3, 3, 0, 0, 1, 3, 1, 2, 3);
    for (int i = 0; i < 5; i++) add(0, 1, 3, 32'hDEAD, 0, 0, 1, 3, 1, 2, 3);
    add(0, 0, 3, 0, 1, 1, 0, 0, 0, 0, 0);
    // Gapped extreme words.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 4, 32'hFFFF_FFFF, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 4, 32'h8000_0000, 1, OVL, 1, 4, 32'hFFFF_FFFF, 0, 32'h8000_0000);
    add(0, 0, 4, 0, 1, 1, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      else begin
        cyc(tbl[i].v, tbl[i].f, tbl[i].d, tbl[i].mr, acc);
        chk($sformatf("tbl%0d_val", i), muldivreq_val, tbl[i].e_val);
        chk($sformatf("tbl%0d_rdy", i), in_rdy, tbl[i].e_rdy);
        if (tbl[i].e_val)
          chk($sformatf("tbl%0d_req", i),
              {muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_msg_c},
              {tbl[i].e_fn, tbl[i].e_a, tbl[i].e_b, tbl[i].e_c});
      end
    end
    chk("tbl_req_count", dut_req, 3);

    // fn mismatch is sticky across clean requests.
    do_reset();
    cyc(1, 2, 10, 1, acc);
    cyc(1, 5, 11, 1, acc);
    chk("mm_err_after_b", err_fn_mismatch, 1);
    cyc(1, 2, 12, 1, acc);
    chk("mm_fn_kept", muldivreq_msg_fn, 2);
    cyc(0, 2, 0, 1, acc);
    for (int i = 0; i < 3; i++) cyc(1, 6, i, 1, acc);
    cyc(0, 6, 0, 1, acc);
    chk("mm_err_sticky", err_fn_mismatch, 1);

    // Reset after word B discards the partial request.
    base = dut_req;
    cyc(1, 6, 100, 0, acc);
    cyc(1, 6, 200, 0, acc);
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(1, 1, i, 1, acc);
    chk("rb_req", {muldivreq_val, muldivreq_msg_a, muldivreq_msg_b, muldivreq_msg_c},
        {1'b1, 32'd1, 32'd2, 32'd3});
    cyc(0, 1, 0, 1, acc);
    chk("rb_count", dut_req - base, 1);

    // Back-to-back throughput.
    do_reset();
    base = dut_req;
    w6 = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    wi = 0;
    for (int n = 1; n <= 12; n++) begin
      if (muldivreq_val) vc.push_back(n);
      cyc(wi < 6, 3'd7, (wi < 6) ? w6[wi] : 32'h0, 1, acc);
      if (acc) wi++;
    end
    chk("b2b_words", wi, 6);
    chk("b2b_count", dut_req - base, 2);
    chk("b2b_nval", vc.size(), 2);
    if (vc.size() >= 2) begin
      chk("b2b_cyc1", vc[0], 4);
      chk("b2b_cyc2", vc[1], OVL ? 7 : 8);
    end

    // Random traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else cyc($urandom_range(0, 3) != 0, FN_W'($urandom_range(0, 1)), $urandom,
               $urandom_range(0, 2) != 0, acc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
